gp_acmp_scan_ctrl: RTL and testbench
====================================

Name: gp_acmp_scan_ctrl

Overview:
Sequencer that time-shares one GreenPAK analog comparator (GP_ACMP) across NUM_CH analog inputs through an external mux.
- Waits for the bandgap OK flag, powers the comparator and waits out power-up.
- Per channel: drives the mux select, waits a settle interval, majority-votes several comparator samples and latches one result bit.
- Sits between the analog hard IP (GP_BANDGAP, GP_ACMP, analog mux) and digital logic that consumes the per-channel threshold flags.

Parameters:
NUM_CH, 4, number of multiplexed channels (2..16)
SEL_W, 2, width of CH_SEL; must satisfy 2**SEL_W >= NUM_CH
PWRUP_CYCLES, 16, cycles from PWREN rising to the first channel settle (1..255)
SETTLE_CYCLES, 4, cycles after each CH_SEL change before sampling (1..255)
SAMPLES, 3, comparator samples per channel; odd, 1..15

Ports:
CLK  in  1  clock; all state changes on rising edge
RST  in  1  synchronous reset, active-high
EN  in  1  scan enable; level-sensitive
BG_OK  in  1  bandgap-ready flag (GP_BANDGAP.OK)
ACMP_OUT  in  1  comparator output, already synchronous to CLK
ACMP_PWREN  out  1  comparator power enable (GP_ACMP.PWREN)
CH_SEL  out  SEL_W  analog mux select
RESULT  out  NUM_CH  latched per-channel comparator result
SCAN_DONE  out  1  one-cycle pulse: full scan complete
BUSY  out  1  high in every state except IDLE
BG_FAULT  out  1  one-cycle pulse: BG_OK lost while powered

Behaviour:
- Clock and reset: one clock (CLK); reset (RST) is synchronous and active-high.
- Reset values: state IDLE; ACMP_PWREN=0, CH_SEL=0, RESULT=0, SCAN_DONE=0, BUSY=0, BG_FAULT=0; all counters 0.
- Reset mid-operation: on the next edge, return to IDLE with the reset values above; discard any partial vote.
- Outputs: all registered, no combinational input-to-output paths.
- Parameter checks: an illegal parameter (SAMPLES even, any count 0, 2**SEL_W < NUM_CH) triggers $display of an error plus $finish at simulation start.
- States:
  - IDLE: PWREN=0. EN=1 -> WAIT_BG.
  - WAIT_BG: PWREN=0, CH_SEL=0. BG_OK=1 -> PWRUP with PWREN=1, counter loaded with PWRUP_CYCLES. EN=0 here -> IDLE.
  - PWRUP: PWREN=1. Decrement the counter; on the last cycle go to SETTLE (ch=0, counter loaded with SETTLE_CYCLES). Occupies exactly PWRUP_CYCLES cycles.
  - SETTLE: occupies exactly SETTLE_CYCLES cycles with CH_SEL=ch, then SAMPLE. Clear the ones counter on entry.
  - SAMPLE: occupies exactly SAMPLES cycles. Add ACMP_OUT to the ones counter each cycle. On the edge ending the last cycle, RESULT[ch] <= (ones incl. the final sample) > SAMPLES/2, then go to NEXT.
  - NEXT: 1 cycle.
    - If ch < NUM_CH-1: ch++, CH_SEL updates, go to SETTLE.
    - Else: SCAN_DONE=1 during this cycle. If EN=1, go to SETTLE with ch=0 and PWREN kept at 1 (no re-power-up). If EN=0, go to IDLE with PWREN=0.
- EN deasserted mid-scan: the current scan completes, then the block goes to IDLE.
- Consistent RESULT snapshot: RESULT bits not yet rewritten in the current scan hold their previous-scan values.
- BG_OK=0 in PWRUP/SETTLE/SAMPLE/NEXT:
  - Next state is WAIT_BG with PWREN=0 and CH_SEL=0.
  - BG_FAULT pulses for 1 cycle (the cycle after the edge).
  - The in-progress vote is discarded and RESULT is unchanged. SCAN_DONE is not asserted, even if the abort coincides with the last NEXT.
  - Abort takes priority over all other transitions.
- Counter widths: 8-bit delay counter; ones counter of $clog2(SAMPLES+1) bits; no wrap is possible within the legal ranges.
- Timing (defaults; cycle n = cycle after edge n):
  - EN=1 and BG_OK=1 from cycle 0 gives WAIT_BG in c1 and PWRUP in c2..c17.
  - Per channel: SETTLE+SAMPLE+NEXT = 8 cycles (ch0 SETTLE c18..21, SAMPLE c22..24, NEXT c25).
  - Last channel NEXT in c49, so SCAN_DONE=1 in c49.
  - Back-to-back scans repeat every NUM_CH*(SETTLE_CYCLES+SAMPLES+1) = 32 cycles.

Test Plan:
- Reset, then EN=1 with BG_OK=1 at cycle 0 and ACMP_OUT tied per channel to 1,0,1,1 -> PWREN rises c2; CH_SEL 0,1,2,3 at c18,c26,c34,c42; SCAN_DONE only in c49; RESULT=4'b1101.
- Majority vote: on ch2, ACMP_OUT samples 1,0,1 -> RESULT[2]=1; samples 0,1,0 -> RESULT[2]=0; SAMPLES=1 build -> result follows the single sample.
- EN held high -> second SCAN_DONE at c81, PWREN never drops, no second PWRUP; EN dropped at c30 -> scan finishes, SCAN_DONE c49, IDLE with PWREN=0 at c50.
- BG_OK held low 10 cycles after EN -> stays in WAIT_BG with PWREN=0, BUSY=1; BG_OK rising at c12 -> PWREN=1 from c13.
- BG_OK dropped during ch1 SAMPLE -> BG_FAULT one cycle, PWREN=0, RESULT unchanged, no SCAN_DONE; BG_OK restored -> full PWRUP again, scan restarts at ch0.
- RST asserted during ch3 SETTLE -> all outputs 0 next cycle including RESULT; RST and EN both high -> stays in IDLE.

Source files
------------

// File: rtl/gp_acmp_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : gp_acmp_scan_ctrl
//  Purpose  : Time-shares one GreenPAK analog comparator across NUM_CH
//             inputs behind an external analog mux. Waits for the bandgap,
//             powers the comparator, then for each channel drives the mux
//             select, waits for settling, majority-votes SAMPLES comparator
//             readings and latches one result bit per channel.
//  Ports    : CLK        - clock, all state changes on rising edge
//             RST        - synchronous active-high reset
//             EN         - scan enable (level)
//             BG_OK      - bandgap ready flag
//             ACMP_OUT   - comparator output (synchronous to CLK)
//             ACMP_PWREN - comparator power enable
//             CH_SEL     - analog mux select
//             RESULT     - latched per-channel comparator results
//             SCAN_DONE  - one-cycle pulse, full scan complete
//             BUSY       - high whenever not idle
//             BG_FAULT   - one-cycle pulse, bandgap lost while powered
//  Revision : 1.0 - initial release
// ============================================================================
module gp_acmp_scan_ctrl #(
    parameter int NUM_CH        = 4,
    parameter int SEL_W         = 2,
    parameter int PWRUP_CYCLES  = 16,
    parameter int SETTLE_CYCLES = 4,
    parameter int SAMPLES       = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              BG_OK,
    input  logic              ACMP_OUT,
    output logic              ACMP_PWREN,
    output logic [SEL_W-1:0]  CH_SEL,
    output logic [NUM_CH-1:0] RESULT,
    output logic              SCAN_DONE,
    output logic              BUSY,
    output logic              BG_FAULT
);

    localparam int ONES_W = $clog2(SAMPLES + 1);

    localparam logic [SEL_W-1:0]  c_last_ch = SEL_W'(NUM_CH - 1);
    localparam logic [ONES_W:0]   c_half    = (ONES_W + 1)'(SAMPLES / 2);
    localparam logic [7:0]        c_pwrup   = 8'(PWRUP_CYCLES);
    localparam logic [7:0]        c_settle  = 8'(SETTLE_CYCLES);
    localparam logic [7:0]        c_samples = 8'(SAMPLES);

`ifndef SYNTHESIS
    generate
        if ((SAMPLES % 2) == 0 || SAMPLES < 1 || PWRUP_CYCLES < 1 ||
            SETTLE_CYCLES < 1 || NUM_CH < 1 || (1 << SEL_W) < NUM_CH) begin : g_bad_params
            initial begin
                $display("ERROR: gp_acmp_scan_ctrl illegal parameters (NUM_CH=%0d SEL_W=%0d PWRUP=%0d SETTLE=%0d SAMPLES=%0d)",
                         NUM_CH, SEL_W, PWRUP_CYCLES, SETTLE_CYCLES, SAMPLES);
                $finish;
            end
        end
    endgenerate
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_BG = 3'd1,
        S_PWRUP   = 3'd2,
        S_SETTLE  = 3'd3,
        S_SAMPLE  = 3'd4,
        S_NEXT    = 3'd5
    } state_t;

    state_t             r_state,  w_state_nxt;
    logic [7:0]         r_cnt,    w_cnt_nxt;
    logic [ONES_W-1:0]  r_ones,   w_ones_nxt;
    logic [SEL_W-1:0]   r_ch,     w_ch_nxt;
    logic [NUM_CH-1:0]  r_result, w_result_nxt;
    logic               r_done,   w_done_nxt;
    logic               r_fault,  w_fault_nxt;
    logic               r_pwren,  w_pwren_nxt;
    logic               r_busy,   w_busy_nxt;

    logic               w_active;
    logic [ONES_W:0]    w_ones_final;
    logic               w_vote;

    // One extra bit so the final sample can never overflow the tally.
    assign w_ones_final = {1'b0, r_ones} + (ONES_W + 1)'(ACMP_OUT);
    assign w_vote       = (w_ones_final > c_half);
    assign w_active     = (r_state == S_PWRUP)  || (r_state == S_SETTLE) ||
                          (r_state == S_SAMPLE) || (r_state == S_NEXT);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_ones_nxt   = r_ones;
        w_ch_nxt     = r_ch;
        w_result_nxt = r_result;
        w_done_nxt   = 1'b0;
        w_fault_nxt  = 1'b0;

        if (w_active && !BG_OK) begin
            // Bandgap loss overrides everything: drop power, discard the
            // partial vote and leave RESULT untouched.
            w_state_nxt = S_WAIT_BG;
            w_cnt_nxt   = 8'd0;
            w_ones_nxt  = '0;
            w_ch_nxt    = '0;
            w_fault_nxt = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_ch_nxt = '0;
                    if (EN) begin
                        w_state_nxt = S_WAIT_BG;
                    end
                end
                S_WAIT_BG: begin
                    w_ch_nxt = '0;
                    if (!EN) begin
                        w_state_nxt = S_IDLE;
                    end else if (BG_OK) begin
                        w_state_nxt = S_PWRUP;
                        w_cnt_nxt   = c_pwrup;
                    end
                end
                S_PWRUP: begin
                    if (r_cnt <= 8'd1) begin
                        w_state_nxt = S_SETTLE;
                        w_cnt_nxt   = c_settle;
                        w_ch_nxt    = '0;
                        w_ones_nxt  = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - 8'd1;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt <= 8'd1) begin
                        w_state_nxt = S_SAMPLE;
                        w_cnt_nxt   = c_samples;
                        w_ones_nxt  = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - 8'd1;
                    end
                end
                S_SAMPLE: begin
                    if (r_cnt <= 8'd1) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (r_ch == SEL_W'(i)) begin
                                w_result_nxt[i] = w_vote;
                            end
                        end
                        w_state_nxt = S_NEXT;
                        w_cnt_nxt   = 8'd0;
                        w_ones_nxt  = '0;
                        // SCAN_DONE is registered, so raise it on entry to
                        // the final NEXT cycle.
                        w_done_nxt  = (r_ch == c_last_ch);
                    end else begin
                        w_ones_nxt = r_ones + ONES_W'(ACMP_OUT);
                        w_cnt_nxt  = r_cnt - 8'd1;
                    end
                end
                S_NEXT: begin
                    if (r_ch != c_last_ch) begin
                        w_ch_nxt    = r_ch + SEL_W'(1);
                        w_state_nxt = S_SETTLE;
                        w_cnt_nxt   = c_settle;
                    end else if (EN) begin
                        // Comparator stays powered between back-to-back scans.
                        w_ch_nxt    = '0;
                        w_state_nxt = S_SETTLE;
                        w_cnt_nxt   = c_settle;
                    end else begin
                        w_ch_nxt    = '0;
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = 8'd0;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 8'd0;
                    w_ones_nxt  = '0;
                    w_ch_nxt    = '0;
                end
            endcase
        end

        w_pwren_nxt = (w_state_nxt == S_PWRUP)  || (w_state_nxt == S_SETTLE) ||
                      (w_state_nxt == S_SAMPLE) || (w_state_nxt == S_NEXT);
        w_busy_nxt  = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_cnt    <= 8'd0;
            r_ones   <= '0;
            r_ch     <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_fault  <= 1'b0;
            r_pwren  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ones   <= w_ones_nxt;
            r_ch     <= w_ch_nxt;
            r_result <= w_result_nxt;
            r_done   <= w_done_nxt;
            r_fault  <= w_fault_nxt;
            r_pwren  <= w_pwren_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    assign ACMP_PWREN = r_pwren;
    assign CH_SEL     = r_ch;
    assign RESULT     = r_result;
    assign SCAN_DONE  = r_done;
    assign BUSY       = r_busy;
    assign BG_FAULT   = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_gp_acmp_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gp_acmp_scan_ctrl
//  Purpose  : Directed self-checking bench for gp_acmp_scan_ctrl. A second
//             instance built with SAMPLES=1 shares the control inputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gp_acmp_scan_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       EN = 1'b0;
    logic       BG_OK = 1'b0;
    logic       ACMP_OUT, ACMP_OUT1;
    logic       ACMP_PWREN, ACMP_PWREN1;
    logic [1:0] CH_SEL, CH_SEL1;
    logic [3:0] RESULT, RESULT1;
    logic       SCAN_DONE, SCAN_DONE1;
    logic       BUSY, BUSY1;
    logic       BG_FAULT, BG_FAULT1;

    // Comparator model: either a fixed level per mux channel, or a level
    // driven cycle by cycle from the stimulus.
    logic       man_mode = 1'b0;
    logic       man_val  = 1'b0;
    logic [3:0] pat      = 4'b0000;
    logic [3:0] pat1     = 4'b0000;

    assign ACMP_OUT  = man_mode ? man_val : pat[CH_SEL];
    assign ACMP_OUT1 = man_mode ? man_val : pat1[CH_SEL1];

    int cyc;
    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    gp_acmp_scan_ctrl #(
        .NUM_CH(4), .SEL_W(2), .PWRUP_CYCLES(16), .SETTLE_CYCLES(4), .SAMPLES(3)
    ) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .BG_OK(BG_OK), .ACMP_OUT(ACMP_OUT),
        .ACMP_PWREN(ACMP_PWREN), .CH_SEL(CH_SEL), .RESULT(RESULT),
        .SCAN_DONE(SCAN_DONE), .BUSY(BUSY), .BG_FAULT(BG_FAULT)
    );

    gp_acmp_scan_ctrl #(
        .NUM_CH(4), .SEL_W(2), .PWRUP_CYCLES(16), .SETTLE_CYCLES(4), .SAMPLES(1)
    ) dut1 (
        .CLK(CLK), .RST(RST), .EN(EN), .BG_OK(BG_OK), .ACMP_OUT(ACMP_OUT1),
        .ACMP_PWREN(ACMP_PWREN1), .CH_SEL(CH_SEL1), .RESULT(RESULT1),
        .SCAN_DONE(SCAN_DONE1), .BUSY(BUSY1), .BG_FAULT(BG_FAULT1)
    );

    // Advance one cycle and sample just after the edge.
    task automatic tick;
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    // Apply one reset edge (cycle 0), then release reset with EN=1.
    task automatic start_run(input logic bg);
        RST   = 1'b1;
        EN    = 1'b0;
        BG_OK = 1'b0;
        @(posedge CLK);
        #1;
        RST   = 1'b0;
        EN    = 1'b1;
        BG_OK = bg;
        cyc   = 0;
    endtask

    task automatic test_reset;
        RST = 1'b1; EN = 1'b0; BG_OK = 1'b0;
        tick; tick;
        n_cmp++; if (ACMP_PWREN !== 1'b0) begin n_err++; $display("FAIL rst_pwren: got %b want 0", ACMP_PWREN); end
        n_cmp++; if (CH_SEL !== 2'd0) begin n_err++; $display("FAIL rst_chsel: got %0d want 0", CH_SEL); end
        n_cmp++; if (RESULT !== 4'b0000) begin n_err++; $display("FAIL rst_result: got %b want 0000", RESULT); end
        n_cmp++; if (SCAN_DONE !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", SCAN_DONE); end
        n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", BUSY); end
        n_cmp++; if (BG_FAULT !== 1'b0) begin n_err++; $display("FAIL rst_fault: got %b want 0", BG_FAULT); end
        n_cmp++; if (RESULT1 !== 4'b0000) begin n_err++; $display("FAIL rst_result1: got %b want 0000", RESULT1); end
    endtask

    // ch0..3 comparator levels 1,0,1,1 -> RESULT 1101. SAMPLES=1 copy sees 0,1,1,0.
    task automatic test_basic_scan;
        man_mode = 1'b0;
        pat  = 4'b1101;
        pat1 = 4'b0110;
        start_run(1'b1);
        for (int c = 1; c <= 49; c++) begin
            tick;
            n_cmp++; if (SCAN_DONE !== (cyc == 49)) begin n_err++; $display("FAIL scan_done c%0d: got %b want %b", cyc, SCAN_DONE, (cyc == 49)); end
            n_cmp++; if (SCAN_DONE1 !== (cyc == 41)) begin n_err++; $display("FAIL scan_done1 c%0d: got %b want %b", cyc, SCAN_DONE1, (cyc == 41)); end
            case (cyc)
                1: begin
                    n_cmp++; if (ACMP_PWREN !== 1'b0) begin n_err++; $display("FAIL basic_pwren_c1: got %b want 0", ACMP_PWREN); end
                    n_cmp++; if (BUSY !== 1'b1) begin n_err++; $display("FAIL basic_busy_c1: got %b want 1", BUSY); end
                end
                2: begin
                    n_cmp++; if (ACMP_PWREN !== 1'b1) begin n_err++; $display("FAIL basic_pwren_c2: got %b want 1", ACMP_PWREN); end
                end
                18: begin n_cmp++; if (CH_SEL !== 2'd0) begin n_err++; $display("FAIL basic_chsel_c18: got %0d want 0", CH_SEL); end end
                25: begin n_cmp++; if (RESULT !== 4'b0001) begin n_err++; $display("FAIL basic_result_c25: got %b want 0001", RESULT); end end
                26: begin n_cmp++; if (CH_SEL !== 2'd1) begin n_err++; $display("FAIL basic_chsel_c26: got %0d want 1", CH_SEL); end end
                33: begin n_cmp++; if (RESULT !== 4'b0001) begin n_err++; $display("FAIL basic_result_c33: got %b want 0001", RESULT); end end
                34: begin n_cmp++; if (CH_SEL !== 2'd2) begin n_err++; $display("FAIL basic_chsel_c34: got %0d want 2", CH_SEL); end end
                41: begin n_cmp++; if (RESULT !== 4'b0101) begin n_err++; $display("FAIL basic_result_c41: got %b want 0101", RESULT); end end
                42: begin
                    n_cmp++; if (CH_SEL !== 2'd3) begin n_err++; $display("FAIL basic_chsel_c42: got %0d want 3", CH_SEL); end
                    n_cmp++; if (RESULT1 !== 4'b0110) begin n_err++; $display("FAIL basic_result1: got %b want 0110", RESULT1); end
                end
                49: begin n_cmp++; if (RESULT !== 4'b1101) begin n_err++; $display("FAIL basic_result_c49: got %b want 1101", RESULT); end end
                default: ;
            endcase
        end
    endtask

    // Continues from test_basic_scan with EN still high.
    task automatic test_back_to_back;
        pat = 4'b0010;
        for (int c = 50; c <= 82; c++) begin
            tick;
            n_cmp++; if (ACMP_PWREN !== 1'b1) begin n_err++; $display("FAIL b2b_pwren c%0d: got %b want 1", cyc, ACMP_PWREN); end
            n_cmp++; if (SCAN_DONE !== (cyc == 81)) begin n_err++; $display("FAIL b2b_done c%0d: got %b want %b", cyc, SCAN_DONE, (cyc == 81)); end
            if (cyc == 50) begin
                n_cmp++; if (CH_SEL !== 2'd0) begin n_err++; $display("FAIL b2b_chsel_c50: got %0d want 0", CH_SEL); end
            end
            if (cyc == 57) begin
                n_cmp++; if (RESULT !== 4'b1100) begin n_err++; $display("FAIL b2b_snapshot_c57: got %b want 1100", RESULT); end
            end
            if (cyc == 81) begin
                n_cmp++; if (RESULT !== 4'b0010) begin n_err++; $display("FAIL b2b_result_c81: got %b want 0010", RESULT); end
            end
        end
    endtask

    // ch2 samples in c38..40, then c70..72, then c102..104.
    task automatic test_majority_vote;
        man_mode = 1'b1;
        man_val  = 1'b0;
        start_run(1'b1);
        for (int c = 1; c <= 105; c++) begin
            tick;
            case (cyc)
                35: begin n_cmp++; if (RESULT1 !== 4'b0100) begin n_err++; $display("FAIL vote_single_sample: got %b want 0100", RESULT1); end end
                41: begin n_cmp++; if (RESULT !== 4'b0100) begin n_err++; $display("FAIL vote_101: got %b want 0100", RESULT); end end
                73: begin n_cmp++; if (RESULT !== 4'b0000) begin n_err++; $display("FAIL vote_010: got %b want 0000", RESULT); end end
                105: begin n_cmp++; if (RESULT !== 4'b0100) begin n_err++; $display("FAIL vote_011: got %b want 0100", RESULT); end end
                default: ;
            endcase
            case (cyc)
                34, 38, 40, 71, 103, 104: man_val = 1'b1;
                default:                   man_val = 1'b0;
            endcase
        end
        man_mode = 1'b0;
    endtask

    task automatic test_en_drop;
        man_mode = 1'b0;
        pat = 4'b1011;
        start_run(1'b1);
        for (int c = 1; c <= 51; c++) begin
            tick;
            n_cmp++; if (SCAN_DONE !== (cyc == 49)) begin n_err++; $display("FAIL endrop_done c%0d: got %b want %b", cyc, SCAN_DONE, (cyc == 49)); end
            if (cyc == 49) begin
                n_cmp++; if (RESULT !== 4'b1011) begin n_err++; $display("FAIL endrop_result: got %b want 1011", RESULT); end
            end
            if (cyc == 50) begin
                n_cmp++; if (ACMP_PWREN !== 1'b0) begin n_err++; $display("FAIL endrop_pwren_c50: got %b want 0", ACMP_PWREN); end
                n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL endrop_busy_c50: got %b want 0", BUSY); end
                n_cmp++; if (CH_SEL !== 2'd0) begin n_err++; $display("FAIL endrop_chsel_c50: got %0d want 0", CH_SEL); end
            end
            if (cyc == 51) begin
                n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL endrop_busy_c51: got %b want 0", BUSY); end
            end
            if (cyc == 30) EN = 1'b0;
        end
    endtask

    task automatic test_bg_wait;
        start_run(1'b0);
        for (int c = 1; c <= 14; c++) begin
            tick;
            if (cyc <= 12) begin
                n_cmp++; if (ACMP_PWREN !== 1'b0) begin n_err++; $display("FAIL bgwait_pwren c%0d: got %b want 0", cyc, ACMP_PWREN); end
                n_cmp++; if (BUSY !== 1'b1) begin n_err++; $display("FAIL bgwait_busy c%0d: got %b want 1", cyc, BUSY); end
            end else begin
                n_cmp++; if (ACMP_PWREN !== 1'b1) begin n_err++; $display("FAIL bgwait_pwren_on c%0d: got %b want 1", cyc, ACMP_PWREN); end
            end
            if (cyc == 12) BG_OK = 1'b1;
        end
    endtask

    task automatic test_bg_fault;
        man_mode = 1'b0;
        pat = 4'b1111;
        start_run(1'b1);
        for (int c = 1; c <= 91; c++) begin
            tick;
            n_cmp++; if (SCAN_DONE !== (cyc == 49)) begin n_err++; $display("FAIL bgf_done c%0d: got %b want %b", cyc, SCAN_DONE, (cyc == 49)); end
            n_cmp++; if (BG_FAULT !== (cyc == 64)) begin n_err++; $display("FAIL bgf_fault c%0d: got %b want %b", cyc, BG_FAULT, (cyc == 64)); end
            case (cyc)
                49: begin n_cmp++; if (RESULT !== 4'b1111) begin n_err++; $display("FAIL bgf_result_c49: got %b want 1111", RESULT); end end
                62: begin n_cmp++; if (RESULT !== 4'b1110) begin n_err++; $display("FAIL bgf_result_c62: got %b want 1110", RESULT); end end
                64: begin
                    n_cmp++; if (ACMP_PWREN !== 1'b0) begin n_err++; $display("FAIL bgf_pwren_c64: got %b want 0", ACMP_PWREN); end
                    n_cmp++; if (CH_SEL !== 2'd0) begin n_err++; $display("FAIL bgf_chsel_c64: got %0d want 0", CH_SEL); end
                    n_cmp++; if (RESULT !== 4'b1110) begin n_err++; $display("FAIL bgf_result_c64: got %b want 1110", RESULT); end
                    n_cmp++; if (BUSY !== 1'b1) begin n_err++; $display("FAIL bgf_busy_c64: got %b want 1", BUSY); end
                end
                66: begin n_cmp++; if (ACMP_PWREN !== 1'b0) begin n_err++; $display("FAIL bgf_pwren_c66: got %b want 0", ACMP_PWREN); end end
                67: begin n_cmp++; if (ACMP_PWREN !== 1'b1) begin n_err++; $display("FAIL bgf_pwren_c67: got %b want 1", ACMP_PWREN); end end
                83: begin n_cmp++; if (CH_SEL !== 2'd0) begin n_err++; $display("FAIL bgf_chsel_c83: got %0d want 0", CH_SEL); end end
                90: begin n_cmp++; if (RESULT !== 4'b1111) begin n_err++; $display("FAIL bgf_result_c90: got %b want 1111", RESULT); end end
                91: begin n_cmp++; if (CH_SEL !== 2'd1) begin n_err++; $display("FAIL bgf_chsel_c91: got %0d want 1", CH_SEL); end end
                default: ;
            endcase
            if (cyc == 49) pat = 4'b0000;
            if (cyc == 63) BG_OK = 1'b0;
            if (cyc == 66) begin BG_OK = 1'b1; pat = 4'b0001; end
        end
    endtask

    task automatic test_reset_mid;
        man_mode = 1'b0;
        pat = 4'b1111;
        start_run(1'b1);
        for (int c = 1; c <= 42; c++) begin
            tick;
            if (cyc == 41) begin
                n_cmp++; if (RESULT !== 4'b0111) begin n_err++; $display("FAIL rmid_result_c41: got %b want 0111", RESULT); end
            end
        end
        n_cmp++; if (CH_SEL !== 2'd3) begin n_err++; $display("FAIL rmid_chsel_c42: got %0d want 3", CH_SEL); end
        RST = 1'b1;
        tick;
        n_cmp++; if (ACMP_PWREN !== 1'b0) begin n_err++; $display("FAIL rmid_pwren: got %b want 0", ACMP_PWREN); end
        n_cmp++; if (CH_SEL !== 2'd0) begin n_err++; $display("FAIL rmid_chsel: got %0d want 0", CH_SEL); end
        n_cmp++; if (RESULT !== 4'b0000) begin n_err++; $display("FAIL rmid_result: got %b want 0000", RESULT); end
        n_cmp++; if (SCAN_DONE !== 1'b0) begin n_err++; $display("FAIL rmid_done: got %b want 0", SCAN_DONE); end
        n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b want 0", BUSY); end
        n_cmp++; if (BG_FAULT !== 1'b0) begin n_err++; $display("FAIL rmid_fault: got %b want 0", BG_FAULT); end
        for (int c = 0; c < 2; c++) begin
            tick;
            n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL rst_en_busy c%0d: got %b want 0", cyc, BUSY); end
            n_cmp++; if (ACMP_PWREN !== 1'b0) begin n_err++; $display("FAIL rst_en_pwren c%0d: got %b want 0", cyc, ACMP_PWREN); end
        end
        RST = 1'b0;
        tick;
        n_cmp++; if (BUSY !== 1'b1) begin n_err++; $display("FAIL rel_busy: got %b want 1", BUSY); end
        n_cmp++; if (ACMP_PWREN !== 1'b0) begin n_err++; $display("FAIL rel_pwren_wait: got %b want 0", ACMP_PWREN); end
        tick;
        n_cmp++; if (ACMP_PWREN !== 1'b1) begin n_err++; $display("FAIL rel_pwren_on: got %b want 1", ACMP_PWREN); end
    endtask

    initial begin
        cyc = 0;
        test_reset;
        test_basic_scan;
        test_back_to_back;
        test_majority_vote;
        test_en_drop;
        test_bg_wait;
        test_bg_fault;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Safety net in case a stimulus loop ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
